// File: rtl/interpolate_linear_if.sv
// ---------------------------------------------------------------------------
// interpolate_linear_if
//   Sample and status bundle for the interpolate_linear reconstruction stage.
//   master : the side that supplies decimated samples and clears the flags
//   slave  : the interpolator itself
//   Signals
//     data_valid_i : single-cycle strobe qualifying data_i
//     data_i       : signed decimated sample (gain 2^N)
//     clear_i      : synchronous clear of the sticky error flags
//     data_valid_o : high while the output is interpolating
//     data_o       : signed unity-gain interpolated output
//     underrun_o   : sticky, next sample arrived late
//     overrun_o    : sticky, next sample arrived early
// ---------------------------------------------------------------------------
interface interpolate_linear_if #(
   parameter int INPUT_WIDTH  = 19,
   parameter int OUTPUT_WIDTH = 14
);
   logic                           data_valid_i;
   logic signed [INPUT_WIDTH-1:0]  data_i;
   logic                           clear_i;
   logic                           data_valid_o;
   logic signed [OUTPUT_WIDTH-1:0] data_o;
   logic                           underrun_o;
   logic                           overrun_o;

   modport master (
      output data_valid_i, data_i, clear_i,
      input  data_valid_o, data_o, underrun_o, overrun_o
   );

   modport slave (
      input  data_valid_i, data_i, clear_i,
      output data_valid_o, data_o, underrun_o, overrun_o
   );
endinterface

// File: rtl/interpolate_linear.sv
// ---------------------------------------------------------------------------
// interpolate_linear
//   Full-rate reconstruction stage. Takes decimated samples of gain 2^N that
//   arrive every 2^N clocks and produces a unity-gain, linearly interpolated
//   signal at the full clock rate. Sticky flags report early/late samples.
//   Ports
//     clk_i  : system clock, rising edge
//     rst_ni : asynchronous active-low reset
//     bus    : interpolate_linear_if slave (samples in, interpolated out, flags)
// ---------------------------------------------------------------------------
module interpolate_linear #(
   parameter  int LOG2_INTERP_FACTOR = 5,
   parameter  int INPUT_WIDTH        = 19,
   localparam int OUTPUT_WIDTH       = INPUT_WIDTH - LOG2_INTERP_FACTOR
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   interpolate_linear_if.slave  bus
);

   localparam int N      = LOG2_INTERP_FACTOR;
   localparam int DIFF_W = INPUT_WIDTH + 1;
   localparam int ACC_W  = INPUT_WIDTH + N + 1;

   typedef enum logic [1:0] {
      IDLE,
      PRIME,
      RUN
   } state_e;

   state_e                         state_q,    state_d;
   logic signed [INPUT_WIDTH-1:0]  last_q,     last_d;
   logic signed [DIFF_W-1:0]       diff_q,     diff_d;
   logic signed [ACC_W-1:0]        acc_q,      acc_d;
   logic        [N-1:0]            k_q,        k_d;
   logic                           dvo_q,      dvo_d;
   logic signed [OUTPUT_WIDTH-1:0] dout_q,     dout_d;
   logic                           underrun_q, underrun_d;
   logic                           overrun_q,  overrun_d;

   logic k_last;
   logic set_under;
   logic set_over;

   assign k_last = (k_q == '1);

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      diff_d    = diff_q;
      acc_d     = acc_q;
      k_d       = k_q;
      set_under = 1'b0;
      set_over  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (bus.data_valid_i) begin
               last_d  = bus.data_i;
               state_d = PRIME;
            end
         end
         PRIME, RUN: begin
            if (bus.data_valid_i) begin
               // Restart the ramp at the previous endpoint (scaled to 2^2N
               // gain); diff carries one extra bit for full-scale steps.
               acc_d   = ACC_W'({{(N + 1){last_q[INPUT_WIDTH-1]}}, last_q} << N);
               diff_d  = {bus.data_i[INPUT_WIDTH-1], bus.data_i}
                       - {last_q[INPUT_WIDTH-1], last_q};
               last_d  = bus.data_i;
               k_d     = '0;
               state_d = RUN;
               if ((state_q == RUN) && !k_last) begin
                  set_over = 1'b1;
               end
            end else if (state_q == RUN) begin
               if (!k_last) begin
                  acc_d = acc_q + {{N{diff_q[DIFF_W-1]}}, diff_q};
                  k_d   = k_q + N'(1);
               end else begin
                  // Sample is late: hold the final point of the ramp.
                  set_under = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // acc carries gain 2^2N; arithmetic shift gives floor truncation.
      dout_d     = OUTPUT_WIDTH'(acc_q >>> (2 * N));
      dvo_d      = (state_q == RUN);
      underrun_d = (underrun_q & ~bus.clear_i) | set_under;
      overrun_d  = (overrun_q  & ~bus.clear_i) | set_over;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         last_q     <= '0;
         diff_q     <= '0;
         acc_q      <= '0;
         k_q        <= '0;
         dvo_q      <= 1'b0;
         dout_q     <= '0;
         underrun_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         diff_q     <= diff_d;
         acc_q      <= acc_d;
         k_q        <= k_d;
         dvo_q      <= dvo_d;
         dout_q     <= dout_d;
         underrun_q <= underrun_d;
         overrun_q  <= overrun_d;
      end
   end

   assign bus.data_valid_o = dvo_q;
   assign bus.data_o       = dout_q;
   assign bus.underrun_o   = underrun_q;
   assign bus.overrun_o    = overrun_q;

endmodule

// File: doc/interpolate_linear.md
Name: interpolate_linear

Overview:
- Full-rate reconstruction stage: the counterpart to the decimate/delay path.
- Accepts decimated, gain-2^N signed samples qualified by a data-valid strobe.
- Outputs a full-clock-rate, unity-gain, linearly interpolated signal that can drive the DAC / feedback output.
- Sticky flags report strobe-timing violations (early or late samples).

Parameters:
- LOG2_INTERP_FACTOR, 5: N. Nominal input strobe spacing is 2^N clocks; the input carries gain 2^N (decimator sum).
- INPUT_WIDTH, 19: width of the signed decimated input (e.g. 14 + N).
- OUTPUT_WIDTH, INPUT_WIDTH-LOG2_INTERP_FACTOR: width of the signed unity-gain output. Derived; do not override.

Ports:
- clk_i  input  1  system clock; all logic on the rising edge. One clock domain only.
- rst_ni  input  1  reset, asynchronous assert, active-low.
- data_valid_i  input  1  single-cycle strobe qualifying data_i.
- data_i  input  INPUT_WIDTH  signed decimated sample (sum of 2^N samples).
- clear_i  input  1  synchronous clear of the sticky error flags.
- data_valid_o  output  1  high while the output is interpolating (state RUN, registered).
- data_o  output  OUTPUT_WIDTH  signed interpolated output, registered.
- underrun_o  output  1  sticky: next sample arrived late.
- overrun_o  output  1  sticky: next sample arrived early.

Behaviour:

Registers:
- last: INPUT_WIDTH.
- diff: INPUT_WIDTH+1, signed.
- acc: INPUT_WIDTH+N+1, signed.
- k: N-bit step counter.
- state: IDLE / PRIME / RUN.

Reset (rst_ni low, asynchronous):
- All registers and outputs are 0; state = IDLE.
- Applies mid-operation too; the first sample after reset is treated as a fresh start.

State machine:
- IDLE: on data_valid_i, last <= data_i; go to PRIME. acc is unchanged (0).
- PRIME or RUN, on data_valid_i (reload):
  - acc <= last <<< N
  - diff <= data_i - last (sign-extended)
  - last <= data_i
  - k <= 0
  - state <= RUN
- RUN, no data_valid_i, k < 2^N-1: acc <= acc + diff; k <= k+1.
- RUN, no data_valid_i, k == 2^N-1: acc and k hold (output freezes); underrun_o <= 1.
- RUN, data_valid_i with k < 2^N-1: perform the reload anyway; overrun_o <= 1.
- RUN, data_valid_i with k == 2^N-1: nominal case, no flag.

Output:
- Every cycle: data_o <= acc >>> 2N (arithmetic shift, floor truncation, no rounding); data_valid_o <= (state == RUN).
- Latency: sample j's value appears on data_o 2 clocks after the strobe of sample j+1. Total reconstruction delay is 2^N+2 clocks.

Width and range:
- acc always lies between consecutive endpoints, so no overflow or saturation logic is required.
- diff needs the extra bit to hold full-scale steps.

Error flags:
- clear_i clears both flags.
- If clear_i and a flag-setting event occur in the same cycle, the flag ends at 1 (set wins).
- Flags are not cleared by returning to nominal timing.

Data_valid_i in IDLE→PRIME does not assert data_valid_o; data_o stays 0 until the first RUN cycle is registered.

Test Plan:
(N=2, INPUT_WIDTH=10 unless stated; strobes every 4 clocks)
1. Reset, then strobes with data_i = 0, 400, 400.
   - data_valid_o rises 2 clocks after the 2nd strobe.
   - data_o sequence: 0, 25, 50, 75, then 100 held while input stays 400.
   - No flags.
2. Negative ramp, strobes 400 then -400: data_o 100, 50, 0, -50, -100. Verify sign extension and floor: (-25)>>>… cases with odd diffs, e.g. 0 → 6 gives 0, 0, 0, 1.
3. Third strobe delayed to 6 clocks.
   - data_o freezes at the k=3 value for 2 cycles.
   - underrun_o = 1 and stays set.
   - clear_i pulse clears it.
   - clear_i asserted in the same cycle as an underrun event leaves underrun_o = 1.
4. Strobe spacing 2 clocks.
   - Reload happens with k=1.
   - overrun_o = 1.
   - Interpolation restarts from the last endpoint, with no jump beyond endpoint values.
5. Assert rst_ni low mid-RUN (asynchronously, between edges).
   - All outputs 0 immediately.
   - After release, a single strobe gives PRIME with data_valid_o = 0.
   - RUN only after the second strobe.
6. Defaults (N=5, INPUT_WIDTH=19), full-scale strobes +2^18-1 and -2^18.
   - data_o reaches 8191 and -8192 exactly.
   - Monotone steps, no overflow.
